// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Arbitrates register-file writeback between the pipeline (port P) and a
// multi-cycle unit (port M). P has fixed priority. A starvation counter
// tracks consecutive stalled cycles on M. When it reaches STARVE_LIMIT, the
// FSM spends one cycle in FORCE, and M is granted unconditionally during
// that cycle. Each accepted transfer becomes a one-cycle registered write
// one cycle later. Writes to register 0 are accepted but never enabled.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   p_valid/p_ready/p_addr/p_data pipeline writeback request
//   m_valid/m_ready/m_addr/m_data multi-cycle unit request
//   we/waddr/wdata                registered register-file write port
//   forced                        high while the FSM is in FORCE
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              forced
);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [3:0]        stall_cnt_q, stall_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              p_xfer, m_xfer;

    // The readies look only at state and p_valid. They never look at
    // m_valid, so M cannot create a combinational path back to itself. Both
    // readies are held low during reset, so nothing is accepted then.
    always_comb begin
        p_ready = 1'b0;
        m_ready = 1'b0;
        if (!rst) begin
            if (state_q == NORMAL) begin
                p_ready = 1'b1;
                m_ready = !p_valid;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    assign p_xfer = p_valid & p_ready;
    assign m_xfer = m_valid & m_ready;

    // Next-state logic and starvation counter.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            NORMAL: begin
                if (m_valid && !m_ready) begin
                    stall_cnt_d = stall_cnt_q + 4'd1;
                    if (stall_cnt_d == LIMIT) begin
                        state_d = FORCE;
                    end
                end else begin
                    // M is idle or was just served.
                    stall_cnt_d = 4'd0;
                end
            end
            FORCE: begin
                // FORCE always lasts exactly one cycle, even if M is idle.
                state_d     = NORMAL;
                stall_cnt_d = 4'd0;
            end
            default: begin
                state_d     = NORMAL;
                stall_cnt_d = 4'd0;
            end
        endcase
    end

    // At most one of p_xfer / m_xfer can be high in a cycle. A write to
    // register 0 is consumed but leaves the write port idle, and the
    // previous address and data are kept.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (p_xfer) begin
            if (p_addr != '0) begin
                we_d    = 1'b1;
                waddr_d = p_addr;
                wdata_d = p_data;
            end
        end else if (m_xfer) begin
            if (m_addr != '0) begin
                we_d    = 1'b1;
                waddr_d = m_addr;
                wdata_d = m_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NORMAL;
            stall_cnt_q <= 4'd0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign we     = we_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign forced = (state_q == FORCE);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              p_valid, m_valid;
    logic              p_ready, m_ready;
    logic [ADDR_W-1:0] p_addr, m_addr;
    logic [DATA_W-1:0] p_data, m_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              forced;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t exp_q[$];

    regfile_wr_arbiter #(.STARVE_LIMIT(4), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_data(p_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .we(we), .waddr(waddr), .wdata(wdata), .forced(forced)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every write-enable pulse must match the oldest expected write,
    // including the cycle it should appear in.
    always @(negedge clk) begin
        if (!rst && we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: got waddr=%h wdata=%h expected no write (cycle %0d)", waddr, wdata, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (waddr !== e.addr || wdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h cycle=%0d expected addr=%h data=%h cycle=%0d",
                             waddr, wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    // One cycle of stimulus. The caller supplies the hand-computed ready and
    // forced values. Writes are expected from those values, not from the DUT.
    task automatic drive(input logic pv, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                         input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                         input logic epr, input logic emr, input logic ef, input string tag);
        wr_t e;
        p_valid = pv; p_addr = pa; p_data = pd;
        m_valid = mv; m_addr = ma; m_data = md;
        @(negedge clk);
        chk({tag, ".p_ready"}, DATA_W'(p_ready), DATA_W'(epr));
        chk({tag, ".m_ready"}, DATA_W'(m_ready), DATA_W'(emr));
        chk({tag, ".forced"},  DATA_W'(forced),  DATA_W'(ef));
        if (pv && epr) begin
            if (pa != 0) begin e.addr = pa; e.data = pd; e.cyc = cyc + 1; exp_q.push_back(e); end
        end else if (mv && emr) begin
            if (ma != 0) begin e.addr = ma; e.data = md; e.cyc = cyc + 1; exp_q.push_back(e); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        p_valid = 0; p_addr = '0; p_data = '0;
        m_valid = 0; m_addr = '0; m_data = '0;
        #12;
        chk("rst.we", DATA_W'(we), '0);
        chk("rst.waddr", DATA_W'(waddr), '0);
        chk("rst.wdata", wdata, '0);
        chk("rst.forced", DATA_W'(forced), '0);
        chk("rst.p_ready", DATA_W'(p_ready), '0);
        chk("rst.m_ready", DATA_W'(m_ready), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // P only.
        drive(1, 5'd3, 32'hDEADBEEF, 0, '0, '0, 1, 0, 0, "p_only");
        idle("p_only.idle");
        idle("p_only.idle2");

        // P and M together: P first, then M.
        drive(1, 5'd4, 32'hA4A4_0004, 1, 5'd5, 32'hB5B5_0005, 1, 0, 0, "both.p");
        drive(0, '0, '0, 1, 5'd5, 32'hB5B5_0005, 1, 1, 0, "both.m");
        idle("both.idle");

        // M writing register 0: accepted, no write enable.
        drive(0, '0, '0, 1, 5'd0, 32'h12345678, 1, 1, 0, "m_r0");
        idle("m_r0.idle");
        idle("m_r0.idle2");

        // Starvation: four stalls, one FORCE cycle, then P again.
        for (int i = 0; i < 4; i++)
            drive(1, 5'd6, 32'h6000_0000 + i, 1, 5'd7, 32'h7777_7777, 1, 0, 0, "starve.stall");
        drive(1, 5'd8, 32'h8888_8888, 1, 5'd7, 32'h7777_7777, 0, 1, 1, "starve.force");
        drive(1, 5'd8, 32'h8888_8888, 0, '0, '0, 1, 0, 0, "starve.back");
        idle("starve.idle");

        // Reset during FORCE: outputs clear at once and the M grant is dropped.
        for (int i = 0; i < 4; i++)
            drive(1, 5'd9, 32'h9000_0000 + i, 1, 5'd10, 32'hAAAA_0010, 1, 0, 0, "rstf.stall");
        p_valid = 1; p_addr = 5'd11; p_data = 32'hBBBB_0011;
        @(negedge clk);
        chk("rstf.forced_before", DATA_W'(forced), 32'd1);
        chk("rstf.m_ready_before", DATA_W'(m_ready), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstf.forced", DATA_W'(forced), '0);
        chk("rstf.we", DATA_W'(we), '0);
        chk("rstf.p_ready", DATA_W'(p_ready), '0);
        chk("rstf.m_ready", DATA_W'(m_ready), '0);
        chk("rstf.waddr", DATA_W'(waddr), '0);
        chk("rstf.wdata", wdata, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = 0;
        drive(1, 5'd11, 32'hBBBB_0011, 0, '0, '0, 1, 0, 0, "rstf.after_p");
        drive(0, '0, '0, 1, 5'd12, 32'hCCCC_0012, 1, 1, 0, "rstf.after_m");
        idle("tail.idle");
        idle("tail.idle2");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive stalled cycles on port M before M is force-granted (legal range 1..15).
REQ-002 SHALL have parameter DATA_W, default 32, the write data width.
REQ-003 SHALL have parameter ADDR_W, default 5, the register address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port p_valid, input, 1 bit: pipeline writeback (port P) request.
REQ-007 SHALL have port p_ready, output, 1 bit: port P accepted this cycle.
REQ-008 SHALL have port p_addr, input, ADDR_W bits: destination register for port P.
REQ-009 SHALL have port p_data, input, DATA_W bits: write data for port P.
REQ-010 SHALL have port m_valid, input, 1 bit: multi-cycle unit (port M) request.
REQ-011 SHALL have port m_ready, output, 1 bit: port M accepted this cycle.
REQ-012 SHALL have port m_addr, input, ADDR_W bits: destination register for port M.
REQ-013 SHALL have port m_data, input, DATA_W bits: write data for port M.
REQ-014 SHALL have port we, output, 1 bit: register file write enable (registered).
REQ-015 SHALL have port waddr, output, ADDR_W bits: register file write address (registered).
REQ-016 SHALL have port wdata, output, DATA_W bits: register file write data (registered).
REQ-017 SHALL have port forced, output, 1 bit: high while the FSM is in FORCE.

Function
REQ-018 SHALL complete a transfer on a port when its valid and ready are both high in the same cycle; requesters keep valid, addr and data stable until accepted.
REQ-019 SHALL accept at most one transfer per cycle.
REQ-020 SHALL implement an FSM with states NORMAL and FORCE, plus a starvation counter stall_cnt (4 bits).
REQ-021 SHALL, in NORMAL, drive p_ready=1 and m_ready=!p_valid, giving fixed priority to P.
REQ-022 SHALL, in FORCE, drive p_ready=0 and m_ready=1.
REQ-023 SHALL derive p_ready and m_ready combinationally from state and p_valid only, never from m_valid.
REQ-024 SHALL, in NORMAL, increment stall_cnt when m_valid=1 and m_ready=0, and clear it when m_valid=0 or an M transfer occurs.
REQ-025 SHALL transition NORMAL->FORCE on the edge where the incremented stall_cnt equals STARVE_LIMIT.
REQ-026 SHALL remain in FORCE for exactly one cycle, then return to NORMAL with stall_cnt=0, whether or not m_valid was high during that cycle.
REQ-027 SHALL register an accepted transfer in cycle N as we=1 with the accepted addr/data in cycle N+1, for exactly one cycle.
REQ-028 SHALL drive we=0 in cycle N+1 when no transfer occurs in cycle N; waddr and wdata then hold their previous values.
REQ-029 SHALL accept a transfer with addr=0 normally but produce we=0 for it; such a transfer still counts as an M transfer for REQ-024.
REQ-030 SHALL treat same-address requests on P and M in the same cycle as ordinary arbitration; ordering is defined solely by acceptance order.

Reset
REQ-031 SHALL, while rst=1, immediately force state=NORMAL, stall_cnt=0, we=0, waddr=0, wdata=0 and forced=0, independent of clk.
REQ-032 SHALL drive p_ready=0 and m_ready=0 while rst=1.
REQ-033 SHALL discard a transfer accepted in the cycle reset asserts; no we pulse follows it.

Verification
REQ-034 Bench SHALL cover: P only, p_addr=3, p_data=0xDEADBEEF -> p_ready=1; next cycle we=1, waddr=3, wdata=0xDEADBEEF, then we=0.
REQ-035 Bench SHALL cover: P and M both valid, P addr=4, M addr=5 -> P accepted; M accepted next cycle once p_valid drops; we pulses for r4 then r5 on consecutive cycles.
REQ-036 Bench SHALL cover: P held valid continuously, M valid, STARVE_LIMIT=4 -> m_ready=0 for 4 cycles; 5th cycle forced=1, p_ready=0, m_ready=1; following cycle back to NORMAL with P accepted.
REQ-037 Bench SHALL cover: M only, m_addr=0, m_data=0x12345678 -> m_ready=1; next cycle we=0.
REQ-038 Bench SHALL cover: rst asserted mid-cycle while in FORCE with stall_cnt=4 -> forced=0, we=0 and both readies 0 immediately; after release p_ready=1 and m_ready=!p_valid.
